// File: rtl/ds1302_responder_if.sv
// ds1302_responder_if: control and status bundle for the DS1302 responder.
//   ds1302_ce, ds1302_sclk : 3-wire link control from the controller
//   sec_tick               : one-clk pulse, advance time by one second
//   wr_pulse, wr_index     : register-commit strobe and index
//   cur_second/minute/hour : live BCD time registers
// The bidirectional ds1302_io pad stays a plain inout port on the module.
interface ds1302_responder_if;
  logic       ds1302_ce;
  logic       ds1302_sclk;
  logic       sec_tick;
  logic       wr_pulse;
  logic [2:0] wr_index;
  logic [7:0] cur_second;
  logic [7:0] cur_minute;
  logic [7:0] cur_hour;

  modport master (
    output ds1302_ce, ds1302_sclk, sec_tick,
    input  wr_pulse, wr_index, cur_second, cur_minute, cur_hour
  );

  modport slave (
    input  ds1302_ce, ds1302_sclk, sec_tick,
    output wr_pulse, wr_index, cur_second, cur_minute, cur_hour
  );
endinterface

// File: rtl/ds1302_responder.sv
// ds1302_responder: DS1302-compatible slave on the CE/SCLK/IO link.
// Decodes single-byte clock-register commands, holds seven BCD time
// registers plus write-protect, answers reads on IO and advances
// sec/min/hour on sec_tick.
//   clk       : system clock, >= 8x SCLK
//   rst       : synchronous reset, active-low
//   bus       : ds1302_responder_if.slave (CE, SCLK, tick, commit, time)
//   ds1302_io : serial data, driven only while presenting read data
module ds1302_responder (
  input  logic               clk,
  input  logic               rst,
  ds1302_responder_if.slave  bus,
  inout  wire                ds1302_io
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RDATA, S_WDATA, S_DONE} state_t;
  state_t state, state_next;

  logic [1:0] ce_sync, sclk_sync, io_sync;
  logic       sclk_prev;
  logic       ce_s, sclk_rise, sclk_fall, io_bit;
  logic [6:0] shift_reg;
  logic [7:0] shift_next;
  logic [3:0] bit_cnt;
  logic [7:0] rd_shift;
  logic [2:0] idx_reg;
  logic       io_out, io_oe;
  logic [7:0] regs [8];
  logic       tick_pend, tick_now;
  logic       byte_done, cmd_ok, do_commit;
  logic       wr_pulse_r;
  logic [2:0] wr_index_r;

  assign ds1302_io      = io_oe ? io_out : 1'bz;
  assign bus.wr_pulse   = wr_pulse_r;
  assign bus.wr_index   = wr_index_r;
  assign bus.cur_second = regs[0];
  assign bus.cur_minute = regs[1];
  assign bus.cur_hour   = regs[2];

  assign ce_s      = ce_sync[1];
  assign io_bit    = io_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign tick_now  = bus.sec_tick | tick_pend;

  // BCD increment keeping bit7; digits outside 0..9 simply count in binary
  // until a 9->0 rollover carries into the tens digit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [6:0] top);
    if (v[6:0] == top)       return {v[7], 7'h00};
    else if (v[3:0] == 4'h9) return {v[7], v[6:4] + 3'd1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      ce_sync   <= '0;
      sclk_sync <= '0;
      io_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[0], bus.ds1302_ce};
      sclk_sync <= {sclk_sync[0], bus.ds1302_sclk};
      io_sync   <= {io_sync[0], ds1302_io};
      sclk_prev <= sclk_sync[1];
    end
  end

  always_comb begin
    state_next = state;
    do_commit  = 1'b0;
    shift_next = {io_bit, shift_reg};
    byte_done  = sclk_rise && (bit_cnt == 4'd7);
    cmd_ok     = shift_next[7] & ~shift_next[6] & (shift_next[5:4] == 2'b00);
    case (state)
      S_IDLE:  if (ce_s) state_next = S_CMD;
      S_CMD: begin
        if (byte_done) begin
          if (!cmd_ok)            state_next = S_DONE;
          else if (shift_next[0]) state_next = S_RDATA;
          else                    state_next = S_WDATA;
        end
      end
      S_RDATA: if (sclk_fall && bit_cnt == 4'd8) state_next = S_DONE;
      S_WDATA: begin
        if (byte_done) begin
          state_next = S_DONE;
          do_commit  = ~regs[7][7] | (idx_reg == 3'd7);
        end
      end
      default: state_next = state;
    endcase
    if (!ce_s) begin
      state_next = S_IDLE;
      do_commit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      rd_shift   <= '0;
      idx_reg    <= '0;
      io_out     <= 1'b0;
      io_oe      <= 1'b0;
      tick_pend  <= 1'b0;
      wr_pulse_r <= 1'b0;
      wr_index_r <= '0;
      regs[0]    <= 8'h00;
      regs[1]    <= 8'h00;
      regs[2]    <= 8'h00;
      regs[3]    <= 8'h01;
      regs[4]    <= 8'h01;
      regs[5]    <= 8'h01;
      regs[6]    <= 8'h00;
      regs[7]    <= 8'h80;
    end else begin
      wr_pulse_r <= 1'b0;
      case (state)
        S_IDLE: bit_cnt <= '0;
        S_CMD: begin
          if (sclk_rise) begin
            shift_reg <= shift_next[7:1];
            bit_cnt   <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              // Snapshot here so a tick during the read cannot tear the byte.
              bit_cnt  <= '0;
              idx_reg  <= shift_next[3:1];
              rd_shift <= regs[shift_next[3:1]];
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            if (bit_cnt != 4'd8) begin
              io_oe    <= 1'b1;
              io_out   <= rd_shift[0];
              rd_shift <= {1'b0, rd_shift[7:1]};
              bit_cnt  <= bit_cnt + 4'd1;
            end else begin
              io_oe <= 1'b0;
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            shift_reg <= shift_next[7:1];
            bit_cnt   <= bit_cnt + 4'd1;
          end
        end
        default: io_oe <= 1'b0;
      endcase
      if (!ce_s) io_oe <= 1'b0;

      // A commit owns the register file this cycle; any tick waits one cycle.
      if (do_commit) begin
        regs[idx_reg] <= shift_next;
        wr_pulse_r    <= 1'b1;
        wr_index_r    <= idx_reg;
        tick_pend     <= tick_now;
      end else begin
        tick_pend <= 1'b0;
        if (tick_now && !regs[0][7]) begin
          regs[0] <= bcd_inc(regs[0], 7'h59);
          if (regs[0][6:0] == 7'h59) begin
            regs[1] <= bcd_inc(regs[1], 7'h59);
            if (regs[1][6:0] == 7'h59) regs[2] <= bcd_inc(regs[2], 7'h23);
          end
        end
      end
    end
  end

endmodule

// File: doc/ds1302_responder.md
# ds1302_responder

Synthesizable DS1302-compatible responder: the slave end of the 3-wire CE/SCLK/IO link driven by the DS1302 controller. It decodes single-byte clock-register commands and holds the seven BCD time registers plus write-protect. It answers reads on IO and advances seconds, minutes and hours on an external 1 Hz tick. It sits on the FPGA pins in place of a physical DS1302, for loopback test and for boards without the chip.

## Interface
- No parameters.
- `clk`  in  1  system clock; must be at least 8x the SCLK frequency.
- `rst`  in  1  synchronous reset, active-low.
- `ds1302_ce`  in  1  chip enable from the controller.
- `ds1302_sclk`  in  1  serial clock from the controller.
- `ds1302_io`  inout  1  serial data. Driven only during read-data phase, otherwise high-Z.
- `sec_tick`  in  1  one-`clk` pulse; advances time by one second.
- `wr_pulse`  out  1  one-`clk` pulse when a register write commits.
- `wr_index`  out  3  register index of the last commit (0..7).
- `cur_second`, `cur_minute`, `cur_hour`  out  8 each  live BCD register contents.

## Operation
- Input capture: CE, SCLK and IO each pass through a 2-flop synchronizer. SCLK rise and fall are one-cycle detect strobes on the synchronized signal.
- Register map (cmd bits 5:1 give the index, LSB-first shift):
  - 0 sec 0x80/0x81; bit7 = CH (clock halt).
  - 1 min 0x82/0x83.
  - 2 hour 0x84/0x85; 24 h only, bit7 stored but ignored.
  - 3 date 0x86/0x87.
  - 4 month 0x88/0x89.
  - 5 week 0x8A/0x8B.
  - 6 year 0x8C/0x8D.
  - 7 WP 0x8E/0x8F; bit7 = write protect.
- Reset values: sec 0x00, min 0x00, hour 0x00, date 0x01, month 0x01, week 0x01, year 0x00, WP 0x80 (protected).
- Other reset values: IO released, `wr_pulse` 0, `wr_index` 0, FSM in S_IDLE.
- S_IDLE: wait for synchronized CE high, then clear the bit counter and go to S_CMD.
- S_CMD: shift IO in on each SCLK rise, LSB first. The 8th rise completes the command byte.
  - If bit7=0, bit6=1 (RAM), or index ≥ 8 (includes burst 0xBE/0xBF): go to S_DONE.
  - Else if bit0=1: go to S_RDATA.
  - Else: go to S_WDATA.
- S_RDATA: on each SCLK fall, drive the next bit of the addressed register, LSB first.
  - The first fall after the 8th command rise presents bit0.
  - After the 8th data bit has been presented, the next fall releases IO; then go to S_DONE.
  - The data byte is snapshotted at command completion, so a tick mid-read does not tear it.
- S_WDATA: shift 8 bits on SCLK rises.
  - On the 8th rise, commit if WP bit7=0 or index=7. The WP register is always writable.
  - A commit writes the register and pulses `wr_pulse` with `wr_index`.
  - If protected, the byte is dropped and no pulse is issued.
  - Then go to S_DONE.
- S_DONE: ignore SCLK and keep IO released until CE goes low, then S_IDLE.
- CE low in any state: abort in the next cycle. Release IO, discard the partial command/data with no commit, and go to S_IDLE.
- Tick: if sec CH=0, increment sec BCD 00..59.
  - 59→00 carries to min 00..59; min 59→00 carries to hour 00..23; 23→00 wraps.
  - Date, month, week and year are not advanced.
  - Sec bit7 is preserved by the increment.
- Tick colliding with a commit in the same cycle: the commit wins. The tick is held pending and applied on the next cycle, so no tick is ever lost.
- Invalid BCD values that were written, e.g. 0x7A, increment to the next binary nibble value until a 9→0 digit rollover. No range check is applied.

## Timing
- IO drive latency: IO is valid 3 `clk` after a physical SCLK fall (2 sync + 1 register). It holds until the next SCLK fall.
- Write commit: the register updates and `wr_pulse` asserts 3 `clk` after the 16th physical SCLK rise.
- Tick: registers update 1 `clk` after `sec_tick`, or 2 `clk` if deferred by a commit.
- CE abort: IO is high-Z within 3 `clk` of the physical CE fall.
- `rst` low overrides everything: at the next `clk` all registers take their reset values and IO is released.

## Test plan
- Reset, then read 0x81 → IO returns 0x00; read 0x87 → 0x01; read 0x8F → 0x80.
- Write 0x80 ← 0x25 with WP=0x80 → no `wr_pulse`, reads back 0x00. Then write 0x8E ← 0x00, then 0x80 ← 0x25 → `wr_pulse` with index 0, reads back 0x25.
- Set hour 0x23, min 0x59, sec 0x59, then one `sec_tick` → 0x00/0x00/0x00. Set sec 0x80 (CH) and tick → sec stays 0x80.
- Run the full controller sequence (WP, 7 writes, 7 reads) against the block → read values equal the written values, one `wr_pulse` per byte.
- Drop CE after 12 SCLK rises of a write to 0x82 → min unchanged, IO high-Z, and the next transaction decodes correctly.
- Assert `sec_tick` in the same cycle as a commit to 0x82 ← 0x10 with sec=0x59 → min = 0x10 first, then the deferred tick gives sec 0x00 and min 0x11.
